eca_engine: RTL and testbench

Parametrised elementary cellular-automaton engine: a WIDTH-cell one-dimensional automaton driven by any of the 256 Wolfram rules, with selectable zero or wrap-around boundary. It runs a programmed number of generations per start command and signals completion with busy/done. It generalises the fixed rule-110, fixed-width, free-running core into a commandable block for the automaton pipeline.

---
 rtl/eca_engine.sv | 120 ++++++++++++
 tb/tb_eca_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eca_engine.sv
// Elementary cellular-automaton engine: WIDTH cells, any Wolfram rule, zero or toroidal
// boundary, runs a commanded number of generations and reports busy/done.
module eca_engine #(
    parameter int WIDTH = 512,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [7:0]       rule,
    input  logic             wrap,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gen_count,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [7:0]         rule_q, rule_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   gen_count_q, gen_count_d;
    logic               done_q, done_d;

    logic [WIDTH+1:0]   ext;
    logic [WIDTH-1:0]   next_gen;

    // Pad the row with its boundary cells so every cell sees a uniform 3-bit window.
    assign ext = {wrap_q & q_q[0], q_q, wrap_q & q_q[WIDTH-1]};

    always_comb begin
        next_gen = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_gen[i] = rule_q[ext[i +: 3]];
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        q_d         = q_q;
        rule_d      = rule_q;
        wrap_d      = wrap_q;
        remaining_d = remaining_q;
        gen_count_d = gen_count_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d         = data;
                    gen_count_d = '0;
                end else if (start) begin
                    if (steps != '0) begin
                        rule_d      = rule;
                        wrap_d      = wrap;
                        remaining_d = steps;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    q_d         = data;
                    gen_count_d = '0;
                    state_d     = IDLE;
                end else begin
                    q_d         = next_gen;
                    gen_count_d = gen_count_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            q_q         <= '0;
            rule_q      <= '0;
            wrap_q      <= 1'b0;
            remaining_q <= '0;
            gen_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            rule_q      <= rule_d;
            wrap_q      <= wrap_d;
            remaining_q <= remaining_d;
            gen_count_q <= gen_count_d;
            done_q      <= done_d;
        end
    end

    assign q         = q_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign gen_count = gen_count_q;
    assign zero      = (q_q == '0);

endmodule

// File: tb/tb_eca_engine.sv
// Self-checking bench for eca_engine: fixed vectors, timing sequences, and random runs
// compared against a rule-table reference model.
module tb_eca_engine;

    logic         clk = 1'b0;
    logic         reset, load, wrap, start;
    logic [7:0]   rule;
    logic [15:0]  steps;
    logic [7:0]   data8;
    logic [511:0] data512;

    logic [7:0]   q8;
    logic         busy8, done8, zero8;
    logic [7:0]   gen8;
    logic [511:0] q512;
    logic         busy512, done512, zero512;
    logic [15:0]  gen512;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eca_engine #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .load(load), .data(data8), .rule(rule), .wrap(wrap),
        .start(start), .steps(steps[7:0]), .q(q8), .busy(busy8), .done(done8),
        .gen_count(gen8), .zero(zero8)
    );

    eca_engine #(.WIDTH(512), .CNT_W(16)) dut512 (
        .clk(clk), .reset(reset), .load(load), .data(data512), .rule(rule), .wrap(wrap),
        .start(start), .steps(steps), .q(q512), .busy(busy512), .done(done512),
        .gen_count(gen512), .zero(zero512)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] rule;
        logic       wrap;
        int         steps;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[12];

    // Reference: each cell looks up bit (4*left + 2*centre + right) of the rule number.
    function automatic logic [511:0] model_step(input logic [511:0] cur, input int w,
                                                input logic [7:0] r, input logic wr);
        logic [511:0] nxt;
        int l, c, rt, pat;
        nxt = '0;
        for (int i = 0; i < w; i++) begin
            c  = cur[i] ? 1 : 0;
            if (i == w - 1) l = (wr && cur[0]) ? 1 : 0;
            else            l = cur[i+1] ? 1 : 0;
            if (i == 0)     rt = (wr && cur[w-1]) ? 1 : 0;
            else            rt = cur[i-1] ? 1 : 0;
            pat = 4 * l + 2 * c + rt;
            nxt[i] = ((int'(r) >> pat) & 1) == 1;
        end
        return nxt;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load8(input logic [7:0] d);
        data8 = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] r, input logic w, input int n);
        rule  = r;
        wrap  = w;
        steps = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done8) break;
        end
        check({tag, "_done"}, done8, 1'b1);
    endtask

    logic [511:0] model;
    logic [7:0]   rd, rr;
    logic         rw;
    int           rn;
    logic         saw_done;

    initial begin
        vecs[0]  = '{8'h01,  8'd90, 1'b1, 1, 8'h82};
        vecs[1]  = '{8'h01,  8'd90, 1'b0, 1, 8'h02};
        vecs[2]  = '{8'hFF,   8'd0, 1'b0, 1, 8'h00};
        vecs[3]  = '{8'hFF,   8'd0, 1'b1, 1, 8'h00};
        vecs[4]  = '{8'h00, 8'd255, 1'b0, 1, 8'hFF};
        vecs[5]  = '{8'h00, 8'd255, 1'b1, 1, 8'hFF};
        vecs[6]  = '{8'hA5, 8'd204, 1'b1, 3, 8'hA5};
        vecs[7]  = '{8'h81, 8'd170, 1'b1, 1, 8'h03};
        vecs[8]  = '{8'h81, 8'd170, 1'b0, 1, 8'h02};
        vecs[9]  = '{8'h81, 8'd240, 1'b1, 1, 8'hC0};
        vecs[10] = '{8'h01, 8'd110, 1'b0, 3, 8'h0D};
        vecs[11] = '{8'h01,  8'd30, 1'b0, 2, 8'h06};

        reset = 1'b1; load = 1'b0; start = 1'b0; wrap = 1'b0;
        rule = '0; steps = '0; data8 = '0; data512 = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_q8", q8, 8'h00);
        check("rst_q512", q512, '0);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_gen", gen8, 8'd0);
        check("rst_zero", zero8, 1'b1);

        // Rule 110 on the full-width instance, single seed cell.
        data512 = 512'd1;
        do_load8(8'h01);
        check("r110_load", q512, 512'd1);
        start_run(8'd110, 1'b0, 3);
        check("r110_busy_t0", busy512, 1'b1);
        tick(); check("r110_t1", q512, 512'h3);
        check("r110_t1_done", done512, 1'b0);
        tick(); check("r110_t2", q512, 512'h7);
        tick(); check("r110_t3", q512, 512'hD);
        check("r110_done", done512, 1'b1);
        check("r110_busy", busy512, 1'b0);
        check("r110_gen", gen512, 16'd3);
        tick(); check("r110_done_pulse", done512, 1'b0);

        foreach (vecs[k]) begin
            do_load8(vecs[k].data);
            start_run(vecs[k].rule, vecs[k].wrap, vecs[k].steps);
            wait_done(vecs[k].steps + 4, $sformatf("vec%0d", k));
            check($sformatf("vec%0d_q", k), q8, vecs[k].exp_q);
            check($sformatf("vec%0d_gen", k), gen8, 8'(vecs[k].steps));
            check($sformatf("vec%0d_zero", k), zero8, vecs[k].exp_q == 8'h00);
            check($sformatf("vec%0d_busy", k), busy8, 1'b0);
        end
        tick();

        // Back-to-back start in the done cycle, then a zero-step start.
        do_load8(8'h01);
        start_run(8'd110, 1'b0, 2);
        tick(); tick();
        check("b2b_done", done8, 1'b1);
        start_run(8'd110, 1'b0, 1);
        check("b2b_accepted", busy8, 1'b1);
        check("b2b_done_clr", done8, 1'b0);
        tick();
        check("b2b_q", q8, 8'h0D);
        check("b2b_gen", gen8, 8'd3);
        check("b2b_done2", done8, 1'b1);
        tick();
        start_run(8'd90, 1'b1, 0);
        check("s0_done", done8, 1'b1);
        check("s0_busy", busy8, 1'b0);
        check("s0_q", q8, 8'h0D);
        check("s0_gen", gen8, 8'd3);
        tick();
        check("s0_pulse", done8, 1'b0);
        check("s0_busy2", busy8, 1'b0);

        // A start during RUN must not change the remaining length.
        do_load8(8'h01);
        start_run(8'd110, 1'b0, 5);
        tick();
        steps = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); check("sib_busy_t3", busy8, 1'b1);
        tick(); check("sib_busy_t4", busy8, 1'b1);
        check("sib_done_t4", done8, 1'b0);
        tick(); check("sib_done_t5", done8, 1'b1);
        check("sib_gen", gen8, 8'd5);
        tick();

        // Abort with load in the 5th RUN cycle.
        do_load8(8'h01);
        start_run(8'd110, 1'b0, 100);
        repeat (4) tick();
        check("abort_gen4", gen8, 8'd4);
        data8 = 8'hAA; load = 1'b1;
        tick();
        load = 1'b0;
        check("abort_q", q8, 8'hAA);
        check("abort_busy", busy8, 1'b0);
        check("abort_gen", gen8, 8'd0);
        saw_done = done8;
        repeat (3) begin tick(); saw_done |= done8; end
        check("abort_no_done", saw_done, 1'b0);
        check("abort_hold", q8, 8'hAA);

        // Reset in the middle of a long run.
        do_load8(8'h01);
        start_run(8'd110, 1'b0, 50);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_q", q8, 8'h00);
        check("mrst_busy", busy8, 1'b0);
        check("mrst_done", done8, 1'b0);
        check("mrst_gen", gen8, 8'd0);
        check("mrst_zero", zero8, 1'b1);
        do_load8(8'h81);
        start_run(8'd170, 1'b1, 2);
        wait_done(6, "mrst_run");
        check("mrst_run_q", q8, 8'h06);
        check("mrst_run_gen", gen8, 8'd2);
        tick();

        // gen_count wraps modulo 2^CNT_W across two runs.
        do_load8(8'h3C);
        start_run(8'd204, 1'b0, 200);
        wait_done(210, "wrap_a");
        start_run(8'd204, 1'b0, 60);
        wait_done(70, "wrap_b");
        check("wrap_gen", gen8, 8'((200 + 60) % 256));
        check("wrap_q", q8, 8'h3C);
        tick();

        // Random rules/patterns, checked every generation.
        for (int it = 0; it < 25; it++) begin
            rd = 8'($urandom);
            rr = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            rn = $urandom_range(1, 12);
            do_load8(rd);
            model = {504'd0, rd};
            start_run(rr, rw, rn);
            for (int k = 1; k <= rn; k++) begin
                tick();
                model = model_step(model, 8, rr, rw);
                check($sformatf("rnd%0d_g%0d", it, k), q8, model[7:0]);
            end
            check($sformatf("rnd%0d_done", it), done8, 1'b1);
            check($sformatf("rnd%0d_gen", it), gen8, 8'(rn));
            tick();
        end

        for (int it = 0; it < 4; it++) begin
            data512 = {16{$urandom}};
            rr = 8'($urandom);
            rw = 1'(it & 1);
            model = data512;
            do_load8(8'h00);
            start_run(rr, rw, 4);
            for (int k = 1; k <= 4; k++) begin
                tick();
                model = model_step(model, 512, rr, rw);
                check($sformatf("w512_%0d_g%0d", it, k), q512, model);
            end
            check($sformatf("w512_%0d_done", it), done512, 1'b1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
